// File: rtl/i2s_tx_tdm.sv
// I2S / TDM serial audio transmitter: SCLK divided from i_mclk, sample FIFO with
// valid/ready push, stereo LRCLK or TDM frame sync, I2S or left-justified framing.
//
// state  | meaning
// IDLE   | stopped; serial outputs held low; FIFO still accepts pushes
// RUN    | serialising frames; a lead-in bit (b = F-1) precedes the first frame
// STOP   | enable dropped mid-frame; finish the frame, then IDLE or back to RUN
module i2s_tx_tdm #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_WIDTH = 32,
    parameter int NUM_CH     = 2,
    parameter int SCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int MODE       = 0
) (
    input  logic                  i_mclk,
    input  logic                  i_mclk_rst_n,
    input  logic                  i_enable,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic                  o_sclk,
    output logic                  o_lrclk,
    output logic                  o_sd,
    output logic                  o_frame_start,
    output logic                  o_underrun
);

    localparam int F  = NUM_CH * SLOT_WIDTH;
    localparam int BW = (F > 1) ? $clog2(F) : 1;
    localparam int CW = $clog2(SCLK_DIV);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);

    localparam logic [BW-1:0] B_LAST  = BW'(F - 1);
    localparam logic [CW-1:0] C_LAST  = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] C_HALF  = CW'(SCLK_DIV / 2);
    localparam logic [NW-1:0] N_CH    = NW'(NUM_CH);
    localparam logic [NW-1:0] N_DEPTH = NW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]         c, c_nxt;
    logic [BW-1:0]         b, b_nxt;
    logic [DATA_WIDTH-1:0] sr;
    logic                  live, live_nxt;

    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [NW-1:0]         count, count_nxt;
    logic                  push, pop;

    logic boundary, bit_end, start, stop_now, advance, new_frame, frame_live, slot_start;

    // Word clock / frame sync level for the bit being entered.
    function automatic logic lr_of(input logic [BW-1:0] idx);
        int bi;
        int nb;
        bi = 32'(idx);
        nb = (bi + 1) % F;
        if (NUM_CH == 2)
            return (MODE == 1) ? (bi >= SLOT_WIDTH) : (nb >= SLOT_WIDTH);
        else
            return (MODE == 1) ? (bi == 0) : (bi == F - 1);
    endfunction

    always_ff @(posedge i_mclk or negedge i_mclk_rst_n) begin
        if (!i_mclk_rst_n) state <= S_IDLE;
        else               state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_enable) state_nxt = S_RUN;
            S_RUN:   if (!i_enable) state_nxt = bit_end ? S_IDLE : S_STOP;
            S_STOP:  if (bit_end) state_nxt = i_enable ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        boundary   = (state != S_IDLE) && (c == C_LAST);
        bit_end    = boundary && (b == B_LAST);
        start      = (state == S_IDLE) && i_enable;
        stop_now   = (state != S_IDLE) && (state_nxt == S_IDLE);
        advance    = boundary && !stop_now;
        new_frame  = advance && (b == B_LAST);
        frame_live = (count >= N_CH);
        live_nxt   = new_frame ? frame_live : live;
        c_nxt      = (c == C_LAST) ? '0 : c + CW'(1);
        b_nxt      = (b == B_LAST) ? '0 : b + BW'(1);
        slot_start = advance && ((32'(b_nxt) % 32'(SLOT_WIDTH)) == 32'd0);
        pop        = slot_start && live_nxt;
        push       = i_tx_valid && o_tx_ready;
    end

    always_ff @(posedge i_mclk or negedge i_mclk_rst_n) begin
        if (!i_mclk_rst_n) begin
            c             <= '0;
            b             <= '0;
            sr            <= '0;
            live          <= 1'b0;
            o_sclk        <= 1'b0;
            o_lrclk       <= 1'b0;
            o_sd          <= 1'b0;
            o_frame_start <= 1'b0;
            o_underrun    <= 1'b0;
        end else begin
            o_frame_start <= 1'b0;
            o_underrun    <= 1'b0;
            if (start) begin
                c       <= '0;
                b       <= B_LAST;
                sr      <= '0;
                live    <= 1'b0;
                o_sclk  <= 1'b0;
                o_lrclk <= lr_of(B_LAST);
                o_sd    <= 1'b0;
            end else if (stop_now) begin
                c       <= '0;
                b       <= '0;
                sr      <= '0;
                live    <= 1'b0;
                o_sclk  <= 1'b0;
                o_lrclk <= 1'b0;
                o_sd    <= 1'b0;
            end else if (state != S_IDLE) begin
                c      <= c_nxt;
                o_sclk <= (c_nxt >= C_HALF);
                if (advance) begin
                    b       <= b_nxt;
                    o_lrclk <= lr_of(b_nxt);
                    live    <= live_nxt;
                    if (new_frame) begin
                        o_frame_start <= 1'b1;
                        o_underrun    <= !frame_live;
                    end
                    // Shifting in zeros makes the pad bits after DATA_WIDTH fall out naturally.
                    if (pop) begin
                        o_sd <= fifo_mem[rd_ptr][DATA_WIDTH-1];
                        sr   <= fifo_mem[rd_ptr] << 1;
                    end else if (live_nxt) begin
                        o_sd <= sr[DATA_WIDTH-1];
                        sr   <= sr << 1;
                    end else begin
                        o_sd <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + NW'(1);
            2'b01:   count_nxt = count - NW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge i_mclk or negedge i_mclk_rst_n) begin
        if (!i_mclk_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_tx_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count      <= count_nxt;
            o_tx_ready <= (count_nxt < N_DEPTH);
        end
    end

    always_ff @(posedge i_mclk) begin
        if (push) fifo_mem[wr_ptr] <= i_tx_data;
    end

endmodule

// File: tb/tb_i2s_tx_tdm.sv
// Directed bench for i2s_tx_tdm: stereo I2S, left-justified and 4-slot TDM
// instances share one stimulus stream; serial bits are captured per SCLK period.
module tb_i2s_tx_tdm;

    logic        mclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] tx_data = '0;
    logic        tx_valid = 1'b0;

    logic [2:0] rdy, sclk, lrclk, sd, fs, ur;

    int checks = 0;
    int errors = 0;
    int sclk_err = 0;

    logic cap_sd  [3][400];
    logic cap_lr  [3][400];
    logic cap_fs  [3][400];
    logic cap_ur  [3][400];
    logic cap_rdy [400];

    always #5 mclk = ~mclk;

    i2s_tx_tdm #(.DATA_WIDTH(16), .SLOT_WIDTH(32), .NUM_CH(2), .SCLK_DIV(4),
                 .FIFO_DEPTH(8), .MODE(0)) dut_i2s (
        .i_mclk(mclk), .i_mclk_rst_n(rst_n), .i_enable(enable),
        .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(rdy[0]),
        .o_sclk(sclk[0]), .o_lrclk(lrclk[0]), .o_sd(sd[0]),
        .o_frame_start(fs[0]), .o_underrun(ur[0]));

    i2s_tx_tdm #(.DATA_WIDTH(16), .SLOT_WIDTH(32), .NUM_CH(2), .SCLK_DIV(4),
                 .FIFO_DEPTH(8), .MODE(1)) dut_lj (
        .i_mclk(mclk), .i_mclk_rst_n(rst_n), .i_enable(enable),
        .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(rdy[1]),
        .o_sclk(sclk[1]), .o_lrclk(lrclk[1]), .o_sd(sd[1]),
        .o_frame_start(fs[1]), .o_underrun(ur[1]));

    i2s_tx_tdm #(.DATA_WIDTH(16), .SLOT_WIDTH(16), .NUM_CH(4), .SCLK_DIV(4),
                 .FIFO_DEPTH(8), .MODE(0)) dut_tdm (
        .i_mclk(mclk), .i_mclk_rst_n(rst_n), .i_enable(enable),
        .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(rdy[2]),
        .o_sclk(sclk[2]), .o_lrclk(lrclk[2]), .o_sd(sd[2]),
        .o_frame_start(fs[2]), .o_underrun(ur[2]));

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not reach its summary in time");
        $fatal(1);
    end

    // One entry per SCLK period; entry 0 follows the enable edge.
    task automatic capture(input int start, input int n);
        for (int k = 0; k < n; k++) begin
            for (int ph = 0; ph < 4; ph++) begin
                @(negedge mclk);
                if (ph == 0) begin
                    for (int d = 0; d < 3; d++) begin
                        cap_sd[d][start+k] = sd[d];
                        cap_lr[d][start+k] = lrclk[d];
                        cap_fs[d][start+k] = 1'b0;
                        cap_ur[d][start+k] = 1'b0;
                    end
                    cap_rdy[start+k] = rdy[0];
                end
                for (int d = 0; d < 3; d++) begin
                    cap_fs[d][start+k] = cap_fs[d][start+k] | fs[d];
                    cap_ur[d][start+k] = cap_ur[d][start+k] | ur[d];
                end
                if (sclk[0] !== (ph >= 2)) sclk_err++;
            end
        end
    endtask

    // 64 captured bits starting at index start, first bit in the MSB.
    function automatic logic [63:0] get_vec(input int kind, input int d, input int start);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) begin
            case (kind)
                0:       v[63-i] = cap_sd[d][start+i];
                1:       v[63-i] = cap_lr[d][start+i];
                2:       v[63-i] = cap_fs[d][start+i];
                default: v[63-i] = cap_ur[d][start+i];
            endcase
        end
        return v;
    endfunction

    task automatic do_reset();
        enable = 1'b0;
        tx_valid = 1'b0;
        @(negedge mclk);
        rst_n = 1'b0;
        repeat (3) @(negedge mclk);
        rst_n = 1'b1;
        @(negedge mclk);
    endtask

    task automatic push(input logic [15:0] d);
        tx_data = d;
        tx_valid = 1'b1;
        @(negedge mclk);
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] outs;
        rst_n = 1'b0;
        repeat (3) @(negedge mclk);
        for (int d = 0; d < 3; d++) begin
            outs = {rdy[d], sclk[d], lrclk[d], sd[d], fs[d], ur[d]};
            checks++;
            if (outs !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got %b exp 000000", d, outs);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (rdy !== 3'b000) begin
            errors++;
            $display("FAIL ready_at_release got %b exp 000", rdy);
        end
        @(negedge mclk);
        checks++;
        if (rdy !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_release got %b exp 111", rdy);
        end
        sclk_err = 0;
        repeat (8) @(negedge mclk) if (sclk !== 3'b000 || sd !== 3'b000) sclk_err++;
        checks++;
        if (sclk_err !== 0) begin
            errors++;
            $display("FAIL idle_quiet got %0d active samples exp 0", sclk_err);
        end
    endtask

    task automatic test_i2s_stereo();
        logic [63:0] v;
        do_reset();
        push(16'hA5A5);
        push(16'h3C3C);
        enable = 1'b1;
        sclk_err = 0;
        capture(0, 65);
        enable = 1'b0;
        checks++;
        if ({cap_sd[0][0], cap_lr[0][0], cap_fs[0][0]} !== 3'b000) begin
            errors++;
            $display("FAIL i2s_leadin got sd/lr/fs %b%b%b exp 000", cap_sd[0][0], cap_lr[0][0], cap_fs[0][0]);
        end
        v = get_vec(0, 0, 1);
        checks++;
        if (v !== 64'hA5A5_0000_3C3C_0000) begin
            errors++;
            $display("FAIL i2s_sd got %h exp %h", v, 64'hA5A5_0000_3C3C_0000);
        end
        v = get_vec(1, 0, 1);
        checks++;
        if (v !== 64'h0000_0001_FFFF_FFFE) begin
            errors++;
            $display("FAIL i2s_lrclk got %h exp %h", v, 64'h0000_0001_FFFF_FFFE);
        end
        v = get_vec(2, 0, 1);
        checks++;
        if (v !== 64'h8000_0000_0000_0000) begin
            errors++;
            $display("FAIL i2s_frame_start got %h exp %h", v, 64'h8000_0000_0000_0000);
        end
        v = get_vec(3, 0, 1);
        checks++;
        if (v !== 64'h0) begin
            errors++;
            $display("FAIL i2s_underrun got %h exp 0", v);
        end
        checks++;
        if (sclk_err !== 0) begin
            errors++;
            $display("FAIL sclk_period got %0d bad samples exp 0", sclk_err);
        end
        repeat (4) @(negedge mclk);
    endtask

    task automatic test_left_justified();
        logic [63:0] v;
        do_reset();
        push(16'hA5A5);
        push(16'h3C3C);
        enable = 1'b1;
        capture(0, 65);
        enable = 1'b0;
        checks++;
        if ({cap_sd[1][0], cap_lr[1][0]} !== 2'b01) begin
            errors++;
            $display("FAIL lj_leadin got sd/lr %b%b exp 01", cap_sd[1][0], cap_lr[1][0]);
        end
        v = get_vec(0, 1, 1);
        checks++;
        if (v !== 64'hA5A5_0000_3C3C_0000) begin
            errors++;
            $display("FAIL lj_sd got %h exp %h", v, 64'hA5A5_0000_3C3C_0000);
        end
        v = get_vec(1, 1, 1);
        checks++;
        if (v !== 64'h0000_0000_FFFF_FFFF) begin
            errors++;
            $display("FAIL lj_lrclk got %h exp %h", v, 64'h0000_0000_FFFF_FFFF);
        end
        repeat (4) @(negedge mclk);
    endtask

    task automatic test_underrun();
        logic [63:0] v;
        do_reset();
        push(16'h1234);
        enable = 1'b1;
        fork
            capture(0, 129);
            begin
                repeat (100) @(negedge mclk);
                push(16'h5678);
            end
        join
        enable = 1'b0;
        v = get_vec(0, 0, 1);
        checks++;
        if (v !== 64'h0) begin
            errors++;
            $display("FAIL muted_sd got %h exp 0", v);
        end
        v = get_vec(3, 0, 1);
        checks++;
        if (v !== 64'h8000_0000_0000_0000) begin
            errors++;
            $display("FAIL muted_underrun got %h exp %h", v, 64'h8000_0000_0000_0000);
        end
        v = get_vec(2, 0, 1);
        checks++;
        if (v !== 64'h8000_0000_0000_0000) begin
            errors++;
            $display("FAIL muted_frame_start got %h exp %h", v, 64'h8000_0000_0000_0000);
        end
        v = get_vec(0, 0, 65);
        checks++;
        if (v !== 64'h1234_0000_5678_0000) begin
            errors++;
            $display("FAIL after_underrun_sd got %h exp %h", v, 64'h1234_0000_5678_0000);
        end
        v = get_vec(3, 0, 65);
        checks++;
        if (v !== 64'h0) begin
            errors++;
            $display("FAIL live_underrun got %h exp 0", v);
        end
        repeat (4) @(negedge mclk);
    endtask

    task automatic test_fifo_full();
        logic [8:0]  seen;
        logic [63:0] v;
        logic [63:0] e;
        do_reset();
        tx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tx_data = 16'(i + 1);
            seen[i] = rdy[0];
            @(negedge mclk);
        end
        tx_valid = 1'b0;
        checks++;
        if (seen !== 9'b0_1111_1111) begin
            errors++;
            $display("FAIL ready_fill got %b exp 011111111", seen);
        end
        enable = 1'b1;
        capture(0, 321);
        enable = 1'b0;
        checks++;
        if ({cap_rdy[0], cap_rdy[1]} !== 2'b01) begin
            errors++;
            $display("FAIL ready_after_pop got %b%b exp 01", cap_rdy[0], cap_rdy[1]);
        end
        for (int f = 0; f < 4; f++) begin
            v = get_vec(0, 0, 1 + 64 * f);
            e = {16'(2 * f + 1), 16'h0, 16'(2 * f + 2), 16'h0};
            checks++;
            if (v !== e) begin
                errors++;
                $display("FAIL full_frame%0d_sd got %h exp %h", f, v, e);
            end
        end
        v = get_vec(3, 0, 257);
        checks++;
        if (v !== 64'h8000_0000_0000_0000) begin
            errors++;
            $display("FAIL drained_underrun got %h exp %h", v, 64'h8000_0000_0000_0000);
        end
        repeat (4) @(negedge mclk);
    endtask

    task automatic test_tdm();
        logic [63:0] v;
        do_reset();
        for (int i = 1; i <= 4; i++) push(16'(i));
        enable = 1'b1;
        capture(0, 129);
        enable = 1'b0;
        checks++;
        if ({cap_sd[2][0], cap_lr[2][0]} !== 2'b01) begin
            errors++;
            $display("FAIL tdm_leadin got sd/lr %b%b exp 01", cap_sd[2][0], cap_lr[2][0]);
        end
        v = get_vec(0, 2, 1);
        checks++;
        if (v !== 64'h0001_0002_0003_0004) begin
            errors++;
            $display("FAIL tdm_sd got %h exp %h", v, 64'h0001_0002_0003_0004);
        end
        v = get_vec(1, 2, 1);
        checks++;
        if (v !== 64'h1) begin
            errors++;
            $display("FAIL tdm_sync0 got %h exp 1", v);
        end
        v = get_vec(1, 2, 65);
        checks++;
        if (v !== 64'h1) begin
            errors++;
            $display("FAIL tdm_sync1 got %h exp 1", v);
        end
        v = get_vec(3, 2, 65);
        checks++;
        if (v !== 64'h8000_0000_0000_0000) begin
            errors++;
            $display("FAIL tdm_underrun got %h exp %h", v, 64'h8000_0000_0000_0000);
        end
        repeat (4) @(negedge mclk);
    endtask

    task automatic test_stop_and_reset();
        logic [63:0] v;
        logic [4:0]  outs;
        int          idle_bad;
        do_reset();
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        push(16'h4444);
        enable = 1'b1;
        sclk_err = 0;
        capture(0, 12);
        enable = 1'b0;
        capture(12, 53);
        v = get_vec(0, 0, 1);
        checks++;
        if (v !== 64'h1111_0000_2222_0000) begin
            errors++;
            $display("FAIL stop_frame_sd got %h exp %h", v, 64'h1111_0000_2222_0000);
        end
        checks++;
        if (sclk_err !== 0) begin
            errors++;
            $display("FAIL stop_sclk got %0d bad samples exp 0", sclk_err);
        end
        idle_bad = 0;
        repeat (8) begin
            @(negedge mclk);
            if ({sclk[0], lrclk[0], sd[0], fs[0]} !== 4'b0) idle_bad++;
        end
        checks++;
        if (idle_bad !== 0) begin
            errors++;
            $display("FAIL stop_to_idle got %0d active samples exp 0", idle_bad);
        end
        enable = 1'b1;
        capture(0, 22);
        v = get_vec(0, 0, 1);
        checks++;
        if (v[63:48] !== 16'h3333) begin
            errors++;
            $display("FAIL resume_sd got %h exp 3333", v[63:48]);
        end
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        outs = {rdy[0], sclk[0], lrclk[0], sd[0], fs[0]};
        checks++;
        if (outs !== 5'b0) begin
            errors++;
            $display("FAIL async_reset got %b exp 00000", outs);
        end
        repeat (2) @(negedge mclk);
        rst_n = 1'b1;
        @(negedge mclk);
        push(16'h5555);
        push(16'h6666);
        enable = 1'b1;
        capture(0, 65);
        enable = 1'b0;
        v = get_vec(0, 0, 1);
        checks++;
        if (v !== 64'h5555_0000_6666_0000) begin
            errors++;
            $display("FAIL flushed_fifo_sd got %h exp %h", v, 64'h5555_0000_6666_0000);
        end
        repeat (4) @(negedge mclk);
    endtask

    initial begin
        test_reset();
        test_i2s_stereo();
        test_left_justified();
        test_underrun();
        test_fifo_full();
        test_tdm();
        test_stop_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
